// File: rtl/stream_pattern_gen_pkg.sv
// Shared definitions for the stream pattern generator.
//   mode_e    : pattern selection carried on cfg_mode
//   state_e   : run-control FSM state
//   LFSR_TAPS : right-shift Galois mask for x^32+x^22+x^2+x+1
package stream_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bit (e-1) is set for each non-leading exponent e of the polynomial
  // (32, 22, 2, 1), so the feedback term is XORed in after the right shift.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/stream_pattern_gen_lfsr32_step.sv
// One step of the 32-bit Galois LFSR (purely combinational).
//   i_state : current LFSR contents
//   o_next  : contents after one shift
module lfsr32_step
  import stream_pattern_gen_pkg::*;
(
  input  logic [31:0] i_state,
  output logic [31:0] o_next
);

  always_comb begin
    o_next = {1'b0, i_state[31:1]};
    if (i_state[0]) begin
      o_next = o_next ^ LFSR_TAPS;
    end
  end

endmodule

// File: rtl/stream_pattern_gen.sv
// Framed test-pattern stream source.
//   clk, aresetn          : clock, asynchronous active-low reset
//   start, stop           : run request (IDLE only) / end run after current frame
//   cfg_*                 : pattern mode, seed, ramp step, frame length, frame count
//   out_valid/ready/data/last : output stream, out_last marks beat N of a frame
//   busy, done, frame_cnt : run status, end-of-run pulse, completed frames
// Stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data and out_last hold and out_valid stays high.
module stream_pattern_gen
  import stream_pattern_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [DATA_W-1:0] cfg_step,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic [CNT_W-1:0]  cfg_num_frames,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_e            r_state;
  state_e            w_state_nxt;
  mode_e             r_mode;
  logic [DATA_W-1:0] r_step;
  logic [LEN_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_num;
  logic [LEN_W-1:0]  r_beat;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [31:0]       r_lfsr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_done;
  logic              r_stop_seen;

  logic              w_hs;
  logic              w_start_ok;
  logic              w_run_end;
  logic [LEN_W-1:0]  w_beat_nxt;
  logic [CNT_W-1:0]  w_frame_cnt_inc;
  logic [31:0]       w_seed_ext;
  logic [31:0]       w_lfsr_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  lfsr32_step u_lfsr_step (
    .i_state (r_lfsr),
    .o_next  (w_lfsr_nxt)
  );

  assign w_hs            = r_valid & out_ready;
  assign w_start_ok      = (r_state == ST_IDLE) & start & (cfg_frame_len != '0);
  assign w_frame_cnt_inc = r_frame_cnt + 1'b1;
  assign w_beat_nxt      = r_last ? LEN_W'(1) : r_beat + 1'b1;

  // The run ends only on a last-beat handshake; a pending or coincident stop
  // therefore always lets the current frame finish.
  assign w_run_end = (r_state == ST_RUN) & w_hs & r_last &
                     (((r_num != '0) && (w_frame_cnt_inc == r_num)) |
                      r_stop_seen | stop);

  // An all-zero LFSR would lock up, so a zero seed loads 1 instead.
  always_comb begin
    w_seed_ext               = '0;
    w_seed_ext[DATA_W-1:0]   = cfg_seed;
    if (w_seed_ext == 32'd0) begin
      w_seed_ext = 32'd1;
    end
  end

  // Constant, ramp and alternating patterns all derive from the sample now
  // on the bus, so no separate seed copy is kept during the run.
  always_comb begin
    w_data_nxt = r_data;
    case (r_mode)
      MODE_CONST: w_data_nxt = r_data;
      MODE_RAMP:  w_data_nxt = r_data + r_step;
      MODE_LFSR:  w_data_nxt = w_lfsr_nxt[DATA_W-1:0];
      MODE_ALT:   w_data_nxt = ~r_data;
      default:    w_data_nxt = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_run_end)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_mode      <= MODE_CONST;
      r_step      <= '0;
      r_len       <= '0;
      r_num       <= '0;
      r_beat      <= '0;
      r_frame_cnt <= '0;
      r_lfsr      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_stop_seen <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_mode      <= mode_e'(cfg_mode);
        r_step      <= cfg_step;
        r_len       <= cfg_frame_len;
        r_num       <= cfg_num_frames;
        r_lfsr      <= w_seed_ext;
        r_beat      <= LEN_W'(1);
        r_valid     <= 1'b1;
        r_last      <= (cfg_frame_len == LEN_W'(1));
        r_frame_cnt <= '0;
        r_stop_seen <= 1'b0;
        if (mode_e'(cfg_mode) == MODE_LFSR) begin
          r_data <= w_seed_ext[DATA_W-1:0];
        end else begin
          r_data <= cfg_seed;
        end
      end else if (r_state == ST_RUN) begin
        if (stop) begin
          r_stop_seen <= 1'b1;
        end
        if (w_hs) begin
          if (r_last) begin
            r_frame_cnt <= w_frame_cnt_inc;
          end
          if (w_run_end) begin
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b1;
            r_stop_seen <= 1'b0;
          end else begin
            r_beat <= w_beat_nxt;
            r_last <= (w_beat_nxt == r_len);
            r_data <= w_data_nxt;
            r_lfsr <= w_lfsr_nxt;
          end
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_stream_pattern_gen.sv
module tb_stream_pattern_gen;

  logic        clk;
  logic        aresetn;
  logic        start;
  logic        stop;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_seed;
  logic [7:0]  cfg_step;
  logic [15:0] cfg_frame_len;
  logic [15:0] cfg_num_frames;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  stream_pattern_gen #(.DATA_W(8), .LEN_W(16), .CNT_W(16)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .start          (start),
    .stop           (stop),
    .cfg_mode       (cfg_mode),
    .cfg_seed       (cfg_seed),
    .cfg_step       (cfg_step),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_num_frames (cfg_num_frames),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .frame_cnt      (frame_cnt)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [8:0]  exp_q[$];     // {last, data}
  logic [15:0] exp_frames;
  int          hs_count    = 0;
  int          last_hs_cyc = 0;
  int          done_cnt    = 0;
  int          n_checks    = 0;
  int          n_err       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference LFSR: right shift, and when a 1 falls out XOR in the
  // polynomial's lower exponents (32,22,2,1 -> bit positions 31,21,1,0).
  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    int exps[4] = '{32, 22, 2, 1};
    logic [31:0] mask;
    mask = '0;
    foreach (exps[k]) mask[exps[k]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  // Expected beat stream of a run of tot beats.
  task automatic push_run(input int mode, input logic [7:0] seed, input logic [7:0] step,
                          input int n, input int tot);
    logic [31:0] st;
    logic [7:0]  d;
    st = (seed == 8'd0) ? 32'd1 : {24'd0, seed};
    for (int i = 0; i < tot; i++) begin
      case (mode)
        0: d = seed;
        1: d = 8'(int'(seed) + i * int'(step));
        2: begin d = st[7:0]; st = ref_lfsr(st); end
        default: d = (i % 2 == 1) ? ~seed : seed;
      endcase
      exp_q.push_back({((i % n) == n - 1), d});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (aresetn) begin
      if (busy) check("no_bubble", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {23'd0, out_last, out_data}, 32'h1ff);
        end else begin
          check("beat", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            last_hs_cyc = cyc;
          end
        end
      end
      if (done) begin
        check("done_timing", cyc, last_hs_cyc + 1);
        check("done_queue_empty", exp_q.size(), 0);
        check("done_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
        check("done_valid_low", {31'd0, out_valid}, 32'd0);
        check("done_busy_low", {31'd0, busy}, 32'd0);
        done_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_cfg_random();
    cfg_mode       = 2'($urandom_range(0, 3));
    cfg_seed       = 8'($urandom);
    cfg_step       = 8'($urandom);
    cfg_frame_len  = 16'($urandom_range(1, 7));
    cfg_num_frames = 16'($urandom_range(0, 3));
  endtask

  // rdy_mode: 0 = always ready, 1 = toggle each cycle, 2 = random
  // stop_at : global beat index (0-based) on which stop is raised, -1 = none
  task automatic run(input int mode, input logic [7:0] seed, input logic [7:0] step,
                     input int n, input int frames, input int stop_at_in, input int rdy_mode);
    int  tot;
    int  stop_at;
    int  d0;
    bit  stop_sent;
    bit  got;
    stop_at = stop_at_in;
    if (frames != 0 && stop_at >= frames * n) stop_at = -1;
    if (stop_at >= 0) tot = (stop_at / n + 1) * n;
    else              tot = frames * n;
    push_run(mode, seed, step, n, tot);
    exp_frames = 16'(tot / n);
    hs_count   = 0;
    stop_sent  = 0;
    // stop while idle must not shorten the coming run
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    cfg_mode       = 2'(mode);
    cfg_seed       = seed;
    cfg_step       = step;
    cfg_frame_len  = 16'(n);
    cfg_num_frames = 16'(frames);
    out_ready      = (rdy_mode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("valid_after_start", {31'd0, out_valid}, 32'd1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    d0  = done_cnt;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      drive_cfg_random();
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      stop  = 1'b0;
      if (stop_at >= 0 && !stop_sent && hs_count == stop_at && busy) begin
        stop      = 1'b1;
        stop_sent = 1;
      end
      start = busy && ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    if (!got) begin
      check("run_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after_run", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_last"},  {31'd0, out_last},  32'd0);
    check({tag, "_data"},  {24'd0, out_data},  32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_done"},  {31'd0, done},      32'd0);
    check({tag, "_fcnt"},  {16'd0, frame_cnt}, 32'd0);
  endtask

  initial begin
    int d0;
    aresetn        = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    out_ready      = 1'b0;
    cfg_mode       = 2'd0;
    cfg_seed       = 8'd0;
    cfg_step       = 8'd0;
    cfg_frame_len  = 16'd0;
    cfg_num_frames = 16'd0;
    exp_frames     = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(posedge clk); #1;

    // ramp wrapping through zero, two frames
    run(1, 8'hFE, 8'h01, 4, 2, -1, 0);
    // constant with ready toggling
    run(0, 8'h5A, 8'h00, 3, 1, -1, 1);
    // LFSR from zero seed
    run(2, 8'h00, 8'h00, 5, 1, -1, 2);
    // continuous run, stop on beat 2 of the first frame
    run(3, 8'hC3, 8'h00, 4, 0, 1, 0);
    // continuous run, stop coincident with the last beat of frame 2
    run(1, 8'h10, 8'h03, 4, 0, 7, 0);
    // single-beat frames
    run(2, 8'h9D, 8'h00, 1, 3, -1, 2);

    // zero frame length: start ignored
    cfg_frame_len = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("len0_busy", {31'd0, busy}, 32'd0);
      check("len0_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      int n, fr, sa;
      n  = $urandom_range(1, 6);
      fr = $urandom_range(0, 3);
      if (fr == 0)                       sa = $urandom_range(0, 3 * n - 1);
      else if ($urandom_range(0, 1) == 1) sa = $urandom_range(0, fr * n - 1);
      else                               sa = -1;
      run($urandom_range(0, 3), 8'($urandom), 8'($urandom), n, fr, sa, 2);
    end

    // asynchronous reset on beat 2 of 4
    push_run(3, 8'h3C, 8'h00, 4, 4);
    exp_frames     = 16'd1;
    hs_count       = 0;
    cfg_mode       = 2'd3;
    cfg_seed       = 8'h3C;
    cfg_frame_len  = 16'd4;
    cfg_num_frames = 16'd1;
    out_ready      = 1'b1;
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && hs_count < 1; c++) begin
      @(posedge clk); #1;
    end
    check("reset_at_beat2", hs_count, 1);
    d0 = done_cnt;
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, d0);
    run(3, 8'h3C, 8'h00, 4, 1, -1, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
